branch_ctrl: RTL and testbench
==============================

# branch_ctrl

Control-step sequencer for the branch/jump instruction class of the datapath. Once the main decoder hands over a decoded instruction, it drives the T3..T6 register-transfer strobes for br, jr and jal. For br it issues the condition-evaluation step and captures the condition-logic result in its own CON flop. It gates the PC write on that captured bit, then reports completion so the fetch sequencer can resume at T0.

## Interface
- OP_BR, 5'b10010: opcode for conditional PC-relative branch
- OP_JR, 5'b10011: opcode for jump register
- OP_JAL, 5'b10100: opcode for jump-and-link (link register R8)

- clock  in  1  system clock, all state on rising edge
- clear  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; decoded instruction valid in IR
- IR  in  32  instruction register; IR[31:27] opcode
- con_in  in  1  combinational condition result from the condition logic (Ra vs. IR[20:19])
- hold  in  1  freeze sequencer (memory/bus stall)
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse in final step of a sequence
- illegal  out  1  one-cycle pulse when start arrives with a non-branch opcode
- con_q  out  1  latched branch condition
- Gra, Rout, CONin, PCout, Yin, Cout, ADD, Zin, Zlowout, PCin, Rin, link_sel  out  1 each  datapath strobes

## Operation
- States: IDLE, T3, T4, T5, T6. Registered `op` holds IR[31:27] captured on start.
- IDLE + start + opcode in {OP_BR, OP_JR, OP_JAL}: capture op, go to T3.
- IDLE + start + other opcode: pulse illegal next cycle and stay IDLE.
- br:
  - T3: Gra, Rout, CONin; con_q <= con_in at the end of T3.
  - T4: PCout, Yin.
  - T5: Cout, ADD, Zin.
  - T6: Zlowout, PCin = con_q, done.
- jr: T3: Gra, Rout, PCin, done.
- jal:
  - T3: PCout, Rin, link_sel (R8 <- PC).
  - T4: Gra, Rout, PCin, done.
- After the done step, return to IDLE.
- All strobes are Moore outputs of state and op. Only PCin in br.T6 depends on con_q.
- con_q is written only in br.T3 and holds otherwise. A not-taken br still walks T4..T6, but PCin stays low.
- busy = (state != IDLE).
- start while busy is ignored, with no illegal pulse.
- hold high: state, op and con_q frozen; all strobes, done and illegal forced 0. The step resumes intact when hold falls.
- hold high in IDLE: start is ignored.

## Timing
- Reset values: state IDLE, op 0, con_q 0, all outputs 0.
- Assertion of clear mid-sequence aborts immediately (asynchronous). The next start is accepted normally after release.
- Latency from start at edge N: T3 at cycle N+1.
  - br: done at N+4, IDLE at N+5, next start accepted at N+5.
  - jal: done at N+2.
  - jr: done at N+1.
- illegal asserts in cycle N+1 only.
- con_q becomes visible in the cycle after T3. con_in is don't-care outside T3.
- Each hold cycle adds exactly one cycle to the remaining latency.

## Structure
- Shared package: opcode constants (OP_BR, OP_JR, OP_JAL) and the state enum, reused by the main control unit.
- Single module, no sub-module. The next-state and strobe decode stay flat in one always block plus one registered process.

## Test plan
- br taken: IR opcode 10010, con_in=1 in T3 → CONin at N+1, Yin at N+2, Zin at N+3, PCin=1 with done at N+4, con_q=1.
- br not taken: con_in=0 in T3, then con_in=1 in T4..T6 → con_q=0, PCin never asserted, done at N+4.
- jr / jal: jr → PCin+done at N+1. jal → Rin+link_sel at N+1, PCin+done at N+2, busy low at N+3.
- Illegal opcode 00011 with start → illegal pulse at N+1, busy stays 0. A start while busy in br.T4 → ignored, sequence unchanged.
- hold: assert hold for 3 cycles during br.T5 → strobes 0 for 3 cycles, Cout/ADD/Zin re-issued after release, done at N+7.
- Reset: clear low during br.T4 → all outputs 0 and con_q 0 asynchronously. A fresh jr after release completes in 1 step.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// Opcodes and step encoding for the branch/jump instruction class, shared with the main control unit.
package branch_ctrl_pkg;

    localparam logic [4:0] OP_BR  = 5'b10010;
    localparam logic [4:0] OP_JR  = 5'b10011;
    localparam logic [4:0] OP_JAL = 5'b10100;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T3   = 3'd1,
        ST_T4   = 3'd2,
        ST_T5   = 3'd3,
        ST_T6   = 3'd4
    } state_e;

    function automatic logic is_branch_op(input logic [4:0] op);
        return (op == OP_BR) || (op == OP_JR) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Handshake, instruction and datapath-strobe bundle between the main decoder, datapath and branch sequencer.
interface branch_ctrl_if;
    logic        start;
    logic [31:0] IR;
    logic        con_in;
    logic        hold;
    logic        busy;
    logic        done;
    logic        illegal;
    logic        con_q;
    logic        Gra, Rout, CONin, PCout, Yin, Cout, ADD, Zin, Zlowout, PCin, Rin, link_sel;

    modport master (
        output start, IR, con_in, hold,
        input  busy, done, illegal, con_q,
        input  Gra, Rout, CONin, PCout, Yin, Cout, ADD, Zin, Zlowout, PCin, Rin, link_sel
    );

    modport slave (
        input  start, IR, con_in, hold,
        output busy, done, illegal, con_q,
        output Gra, Rout, CONin, PCout, Yin, Cout, ADD, Zin, Zlowout, PCin, Rin, link_sel
    );
endinterface

// File: rtl/branch_ctrl.sv
// T3..T6 step sequencer for br/jr/jal; first step one cycle after start, done after 1 (jr), 2 (jal) or 4 (br) steps.
// hold freezes every register and zeroes all strobes, so each hold cycle adds exactly one cycle of latency.
module branch_ctrl
    import branch_ctrl_pkg::*;
(
    input  logic          clock,
    input  logic          clear,
    branch_ctrl_if.slave  bus
);

    state_e     state_q, state_d;
    logic [4:0] op_q, op_d;
    logic       con_q_q, con_q_d;
    logic       illegal_q, illegal_d;
    logic [4:0] ir_op;
    logic       unused_ir;

    assign ir_op     = bus.IR[31:27];
    assign unused_ir = ^bus.IR[26:0];

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q   <= ST_IDLE;
            op_q      <= 5'd0;
            con_q_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            con_q_q   <= con_q_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        con_q_d      = con_q_q;
        illegal_d    = 1'b0;
        bus.done     = 1'b0;
        bus.Gra      = 1'b0;
        bus.Rout     = 1'b0;
        bus.CONin    = 1'b0;
        bus.PCout    = 1'b0;
        bus.Yin      = 1'b0;
        bus.Cout     = 1'b0;
        bus.ADD      = 1'b0;
        bus.Zin      = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.PCin     = 1'b0;
        bus.Rin      = 1'b0;
        bus.link_sel = 1'b0;

        if (!bus.hold) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (is_branch_op(ir_op)) begin
                            op_d    = ir_op;
                            state_d = ST_T3;
                        end else begin
                            illegal_d = 1'b1;
                        end
                    end
                end
                ST_T3: begin
                    state_d = ST_IDLE;
                    case (op_q)
                        OP_BR: begin
                            bus.Gra   = 1'b1;
                            bus.Rout  = 1'b1;
                            bus.CONin = 1'b1;
                            con_q_d   = bus.con_in;
                            state_d   = ST_T4;
                        end
                        OP_JR: begin
                            bus.Gra  = 1'b1;
                            bus.Rout = 1'b1;
                            bus.PCin = 1'b1;
                            bus.done = 1'b1;
                        end
                        OP_JAL: begin
                            // Link first: R8 <- PC before the jump target is written.
                            bus.PCout    = 1'b1;
                            bus.Rin      = 1'b1;
                            bus.link_sel = 1'b1;
                            state_d      = ST_T4;
                        end
                        default: ;
                    endcase
                end
                ST_T4: begin
                    state_d = ST_IDLE;
                    if (op_q == OP_BR) begin
                        bus.PCout = 1'b1;
                        bus.Yin   = 1'b1;
                        state_d   = ST_T5;
                    end else if (op_q == OP_JAL) begin
                        bus.Gra  = 1'b1;
                        bus.Rout = 1'b1;
                        bus.PCin = 1'b1;
                        bus.done = 1'b1;
                    end
                end
                ST_T5: begin
                    state_d  = ST_T6;
                    bus.Cout = 1'b1;
                    bus.ADD  = 1'b1;
                    bus.Zin  = 1'b1;
                end
                ST_T6: begin
                    // A not-taken branch still walks this step; only the PC write is suppressed.
                    state_d     = ST_IDLE;
                    bus.Zlowout = 1'b1;
                    bus.PCin    = con_q_q;
                    bus.done    = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.illegal = illegal_q & ~bus.hold;
    assign bus.con_q   = con_q_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Cycle-by-cycle scoreboard bench for branch_ctrl: each step queues the expected output vector and checks it in that cycle.
module tb_branch_ctrl;
    import branch_ctrl_pkg::*;

    logic clock = 1'b0;
    logic clear = 1'b1;
    always #5 clock = ~clock;

    branch_ctrl_if bif ();
    branch_ctrl dut (.clock(clock), .clear(clear), .bus(bif));

    localparam logic [15:0] LINK  = 16'h0001;
    localparam logic [15:0] RIN   = 16'h0002;
    localparam logic [15:0] PCIN  = 16'h0004;
    localparam logic [15:0] ZLO   = 16'h0008;
    localparam logic [15:0] ZIN   = 16'h0010;
    localparam logic [15:0] ADDS  = 16'h0020;
    localparam logic [15:0] COUT  = 16'h0040;
    localparam logic [15:0] YIN   = 16'h0080;
    localparam logic [15:0] PCOUT = 16'h0100;
    localparam logic [15:0] CONIN = 16'h0200;
    localparam logic [15:0] ROUT  = 16'h0400;
    localparam logic [15:0] GRA   = 16'h0800;
    localparam logic [15:0] CONQ  = 16'h1000;
    localparam logic [15:0] ILL   = 16'h2000;
    localparam logic [15:0] DONE  = 16'h4000;
    localparam logic [15:0] BUSY  = 16'h8000;
    localparam logic [4:0]  OP_BAD = 5'b00011;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    function automatic logic [15:0] obs();
        return {bif.busy, bif.done, bif.illegal, bif.con_q, bif.Gra, bif.Rout, bif.CONin,
                bif.PCout, bif.Yin, bif.Cout, bif.ADD, bif.Zin, bif.Zlowout, bif.PCin,
                bif.Rin, bif.link_sel};
    endfunction

    // One clock cycle: drive inputs after the edge, queue the expectation, check mid-cycle.
    task automatic cyc(input logic st, input logic [4:0] opc, input logic ci, input logic hd,
                       input logic [15:0] ex, input string nm);
        logic [15:0] got;
        logic [15:0] want;
        @(posedge clock);
        #1;
        bif.start  = st;
        bif.IR     = {opc, 27'($urandom)};
        bif.con_in = ci;
        bif.hold   = hd;
        exp_q.push_back(ex);
        #2;
        got  = obs();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %04h expected %04h", nm, got, want);
        end
    endtask

    task automatic test_reset();
        #1 clear = 1'b0;
        cyc(1'b1, OP_BR, 1'b1, 1'b0, 16'h0000, "reset.held_start");
        cyc(1'b0, 5'd0, 1'b0, 1'b0, 16'h0000, "reset.held");
        clear = 1'b1;
        cyc(1'b0, 5'd0, 1'b0, 1'b0, 16'h0000, "reset.released");
    endtask

    task automatic test_br_taken();
        cyc(1'b1, OP_BR, 1'b0, 1'b0, 16'h0000,                     "br_t.start");
        cyc(1'b0, 5'd0,  1'b1, 1'b0, BUSY|GRA|ROUT|CONIN,          "br_t.T3");
        cyc(1'b0, 5'd0,  1'b0, 1'b0, BUSY|PCOUT|YIN|CONQ,          "br_t.T4");
        cyc(1'b0, 5'd0,  1'b0, 1'b0, BUSY|COUT|ADDS|ZIN|CONQ,      "br_t.T5");
        cyc(1'b0, 5'd0,  1'b0, 1'b0, BUSY|ZLO|PCIN|DONE|CONQ,      "br_t.T6");
        cyc(1'b0, 5'd0,  1'b0, 1'b0, CONQ,                         "br_t.idle");
    endtask

    // Also covers start while busy (legal in T4, illegal opcode in T5): both must be ignored.
    task automatic test_br_not_taken();
        cyc(1'b1, OP_BR,  1'b1, 1'b0, CONQ,                        "br_n.start");
        cyc(1'b0, 5'd0,   1'b0, 1'b0, BUSY|GRA|ROUT|CONIN|CONQ,    "br_n.T3");
        cyc(1'b1, OP_JR,  1'b1, 1'b0, BUSY|PCOUT|YIN,              "br_n.T4_start");
        cyc(1'b1, OP_BAD, 1'b1, 1'b0, BUSY|COUT|ADDS|ZIN,          "br_n.T5_start");
        cyc(1'b0, 5'd0,   1'b1, 1'b0, BUSY|ZLO|DONE,               "br_n.T6");
        cyc(1'b0, 5'd0,   1'b1, 1'b0, 16'h0000,                    "br_n.idle");
    endtask

    task automatic test_jr();
        cyc(1'b1, OP_JR, 1'b0, 1'b0, 16'h0000,                     "jr.start");
        cyc(1'b0, 5'd0,  1'b0, 1'b0, BUSY|GRA|ROUT|PCIN|DONE,      "jr.T3");
        cyc(1'b0, 5'd0,  1'b0, 1'b0, 16'h0000,                     "jr.idle");
    endtask

    task automatic test_jal();
        cyc(1'b1, OP_JAL, 1'b0, 1'b0, 16'h0000,                    "jal.start");
        cyc(1'b0, 5'd0,   1'b0, 1'b0, BUSY|PCOUT|RIN|LINK,         "jal.T3");
        cyc(1'b0, 5'd0,   1'b0, 1'b0, BUSY|GRA|ROUT|PCIN|DONE,     "jal.T4");
        cyc(1'b0, 5'd0,   1'b0, 1'b0, 16'h0000,                    "jal.idle");
    endtask

    task automatic test_back_to_back();
        cyc(1'b1, OP_JR,  1'b0, 1'b0, 16'h0000,                    "b2b.jr_start");
        cyc(1'b1, OP_BR,  1'b0, 1'b0, BUSY|GRA|ROUT|PCIN|DONE,     "b2b.jr_T3");
        cyc(1'b1, OP_JAL, 1'b0, 1'b0, 16'h0000,                    "b2b.jal_start");
        cyc(1'b0, 5'd0,   1'b0, 1'b0, BUSY|PCOUT|RIN|LINK,         "b2b.jal_T3");
        cyc(1'b0, 5'd0,   1'b0, 1'b0, BUSY|GRA|ROUT|PCIN|DONE,     "b2b.jal_T4");
        cyc(1'b0, 5'd0,   1'b0, 1'b0, 16'h0000,                    "b2b.idle");
    endtask

    task automatic test_illegal();
        cyc(1'b1, OP_BAD, 1'b0, 1'b0, 16'h0000,                    "ill.start");
        cyc(1'b0, 5'd0,   1'b0, 1'b0, ILL,                         "ill.pulse");
        cyc(1'b0, 5'd0,   1'b0, 1'b0, 16'h0000,                    "ill.after");
        cyc(1'b1, OP_BR,  1'b0, 1'b1, 16'h0000,                    "ill.hold_start");
        cyc(1'b0, 5'd0,   1'b0, 1'b0, 16'h0000,                    "ill.hold_ignored");
    endtask

    task automatic test_hold();
        cyc(1'b1, OP_BR, 1'b0, 1'b0, 16'h0000,                     "hold.start");
        cyc(1'b0, 5'd0,  1'b1, 1'b0, BUSY|GRA|ROUT|CONIN,          "hold.T3");
        cyc(1'b0, 5'd0,  1'b0, 1'b0, BUSY|PCOUT|YIN|CONQ,          "hold.T4");
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 5'd0, 1'b0, 1'b1, BUSY|CONQ,                 "hold.frozen");
        cyc(1'b0, 5'd0,  1'b0, 1'b0, BUSY|COUT|ADDS|ZIN|CONQ,      "hold.T5");
        cyc(1'b0, 5'd0,  1'b0, 1'b0, BUSY|ZLO|PCIN|DONE|CONQ,      "hold.T6");
        cyc(1'b0, 5'd0,  1'b0, 1'b0, CONQ,                         "hold.idle");
    endtask

    task automatic test_reset_mid();
        logic [15:0] got;
        cyc(1'b1, OP_BR, 1'b0, 1'b0, CONQ,                         "rst.start");
        cyc(1'b0, 5'd0,  1'b1, 1'b0, BUSY|GRA|ROUT|CONIN|CONQ,     "rst.T3");
        cyc(1'b0, 5'd0,  1'b0, 1'b0, BUSY|PCOUT|YIN|CONQ,          "rst.T4");
        #1 clear = 1'b0;
        #1 got = obs();
        checks++;
        if (got !== 16'h0000) begin
            errors++;
            $display("FAIL rst.async: got %04h expected 0000", got);
        end
        cyc(1'b0, 5'd0,  1'b0, 1'b0, 16'h0000,                     "rst.held");
        clear = 1'b1;
        cyc(1'b1, OP_JR, 1'b0, 1'b0, 16'h0000,                     "rst.jr_start");
        cyc(1'b0, 5'd0,  1'b0, 1'b0, BUSY|GRA|ROUT|PCIN|DONE,      "rst.jr_T3");
        cyc(1'b0, 5'd0,  1'b0, 1'b0, 16'h0000,                     "rst.jr_idle");
    endtask

    initial begin
        bif.start  = 1'b0;
        bif.IR     = 32'd0;
        bif.con_in = 1'b0;
        bif.hold   = 1'b0;
        test_reset();
        test_br_taken();
        test_br_not_taken();
        test_jr();
        test_jal();
        test_back_to_back();
        test_illegal();
        test_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
